// File: rtl/range_speed_pkg.sv
// Shared widths, reset constants and the saturating
// closing-speed helper for the range/speed tracker.
package range_speed_pkg;

  localparam int DEF_RANGE_W = 10;
  localparam int DEF_SPEED_W = 8;
  localparam int DEF_CNT_W   = 16;

  localparam logic [DEF_RANGE_W-1:0] DEF_MIN_INIT = '1;

  // Unsigned a-b, zero when b>=a, clipped to 2**speed_w-1
  function automatic logic [31:0] sat_sub(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned speed_w
  );
    logic [31:0] d;
    logic [31:0] lim;
    lim = (32'd1 << speed_w) - 32'd1;
    d   = (a > b) ? (a - b) : 32'd0;
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running clock divider producing a one-clock
// sample tick every TICK_DIV clocks.
module sample_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (o_tick) cnt_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/range_speed_tracker.sv
// Tracks minimum range and peak closing speed of a
// ranging sensor sampled on a divided tick.
module range_speed_tracker
  import range_speed_pkg::*;
#(
  parameter int RANGE_W  = DEF_RANGE_W,
  parameter int SPEED_W  = DEF_SPEED_W,
  parameter int TICK_DIV = 1000,
  parameter int CNT_W    = DEF_CNT_W,
  parameter logic [RANGE_W-1:0] MIN_INIT =
    {RANGE_W{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_range_valid,
  input  logic [RANGE_W-1:0] i_range,
  output logic [RANGE_W-1:0] o_min_range,
  output logic [SPEED_W-1:0] o_max_speed,
  output logic [SPEED_W-1:0] o_last_speed,
  output logic [CNT_W-1:0]   o_sample_cnt,
  output logic               o_update
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic tick;
  logic accept;

  logic [RANGE_W-1:0] min_q,  min_d;
  logic [SPEED_W-1:0] max_q,  max_d;
  logic [SPEED_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic [RANGE_W-1:0] prev_q, prev_d;
  logic               flag_q, flag_d;
  logic               upd_q,  upd_d;
  logic [SPEED_W-1:0] speed;

  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  assign accept = tick & i_range_valid;

  assign speed = SPEED_W'(sat_sub(
    32'(prev_q), 32'(i_range), SPEED_W));

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    prev_d = prev_q;
    flag_d = flag_q;
    upd_d  = 1'b0;
    // clear takes priority and discards a coincident sample
    if (i_clear) begin
      min_d  = MIN_INIT;
      max_d  = '0;
      last_d = '0;
      cnt_d  = '0;
      prev_d = '0;
      flag_d = 1'b0;
    end else if (accept) begin
      upd_d  = 1'b1;
      prev_d = i_range;
      flag_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (i_range < min_q)  min_d = i_range;
      if (!flag_q) begin
        last_d = '0;
      end else begin
        last_d = speed;
        if (speed > max_q) max_d = speed;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      min_q  <= MIN_INIT;
      max_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      prev_q <= '0;
      flag_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      flag_q <= flag_d;
      upd_q  <= upd_d;
    end
  end

  assign o_min_range  = min_q;
  assign o_max_speed  = max_q;
  assign o_last_speed = last_q;
  assign o_sample_cnt = cnt_q;
  assign o_update     = upd_q;

endmodule
